// File: rtl/nnz_pkg.sv
// Shared types, default constants and the configuration legality check
// for the nearest-neighbour zoom block.
package nnz_pkg;

  localparam int PIXEL_W    = 8;
  localparam int MAX_SCALE  = 4;
  localparam int MAX_LINE_W = 320;
  localparam int MAX_LINES  = 240;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } nnz_state_e;

  function automatic logic cfg_legal(input int scale,
                                     input int width,
                                     input int height,
                                     input int max_scale  = MAX_SCALE,
                                     input int max_width  = MAX_LINE_W,
                                     input int max_height = MAX_LINES);
    return (scale  >= 1) && (scale  <= max_scale) &&
           (width  >= 1) && (width  <= max_width) &&
           (height >= 1) && (height <= max_height);
  endfunction

endpackage

// File: rtl/nnz_line_buffer.sv
// Simple dual-port line buffer: synchronous write, registered read that
// only updates when rd_en is high so the read data holds during stalls.
module nnz_line_buffer #(
  parameter int PIXEL_W = 8,
  parameter int DEPTH   = 320,
  parameter int ADDR_W  = 9
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [PIXEL_W-1:0] rd_data
);

  logic [PIXEL_W-1:0] mem [DEPTH];
  logic [PIXEL_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/nearest_neighbor_zoom_nx.sv
// Runtime-factor nearest-neighbour upscaler: buffers one source row, then
// replays it N times with each pixel repeated N times. Optional horizontal
// mirroring is enabled by defining NNZ_HMIRROR_EN.
module nearest_neighbor_zoom_nx #(
  parameter int PIXEL_W    = nnz_pkg::PIXEL_W,
  parameter int MAX_SCALE  = nnz_pkg::MAX_SCALE,
  parameter int MAX_LINE_W = nnz_pkg::MAX_LINE_W,
  parameter int MAX_LINES  = nnz_pkg::MAX_LINES,
  parameter int SCALE_W    = $clog2(MAX_SCALE + 1),
  parameter int COL_W      = $clog2(MAX_LINE_W + 1),
  parameter int ROW_W      = $clog2(MAX_LINES + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [SCALE_W-1:0] scale,
  input  logic [COL_W-1:0]   src_width,
  input  logic [ROW_W-1:0]   src_height,
`ifdef NNZ_HMIRROR_EN
  input  logic               mirror,
`endif
  input  logic               in_valid,
  input  logic [PIXEL_W-1:0] in_pixel,
  output logic               in_ready,
  output logic               out_valid,
  output logic [PIXEL_W-1:0] out_pixel,
  input  logic               out_ready,
  output logic               out_eol,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  import nnz_pkg::*;

  nnz_state_e         state_q, state_d;
  logic [SCALE_W-1:0] scale_m1_q, scale_m1_d;
  logic [COL_W-1:0]   width_m1_q, width_m1_d;
  logic [ROW_W-1:0]   height_m1_q, height_m1_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [SCALE_W-1:0] rep_x_q, rep_x_d;
  logic [SCALE_W-1:0] rep_y_q, rep_y_d;
  logic               issue_done_q, issue_done_d;
  logic               s1_vld_q, s1_vld_d;
  logic               s1_eol_q, s1_eol_d;
  logic               s1_last_q, s1_last_d;
  logic               out_valid_q, out_valid_d;
  logic [PIXEL_W-1:0] out_pixel_q, out_pixel_d;
  logic               out_eol_q, out_eol_d;
  logic               out_last_q, out_last_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;

  logic               wr_en;
  logic               rd_en;
  logic [COL_W-1:0]   rd_addr;
  logic [PIXEL_W-1:0] rd_data;
  logic               rd_eol;
  logic               rd_last;
  logic               out_load;
  logic               s1_adv;
  logic               out_xfer;
  logic               start_legal;

`ifdef NNZ_HMIRROR_EN
  logic mirror_q, mirror_d;
  assign rd_addr = mirror_q ? (width_m1_q - col_q) : col_q;
`else
  assign rd_addr = col_q;
`endif

  assign start_legal = cfg_legal(32'(scale), 32'(src_width), 32'(src_height),
                                 MAX_SCALE, MAX_LINE_W, MAX_LINES);

  nnz_line_buffer #(
    .PIXEL_W (PIXEL_W),
    .DEPTH   (MAX_LINE_W),
    .ADDR_W  (COL_W)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (col_q),
    .wr_data (in_pixel),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    scale_m1_d   = scale_m1_q;
    width_m1_d   = width_m1_q;
    height_m1_d  = height_m1_q;
`ifdef NNZ_HMIRROR_EN
    mirror_d     = mirror_q;
`endif
    row_d        = row_q;
    col_d        = col_q;
    rep_x_d      = rep_x_q;
    rep_y_d      = rep_y_q;
    issue_done_d = issue_done_q;
    s1_vld_d     = s1_vld_q;
    s1_eol_d     = s1_eol_q;
    s1_last_d    = s1_last_q;
    out_valid_d  = out_valid_q;
    out_pixel_d  = out_pixel_q;
    out_eol_d    = out_eol_q;
    out_last_d   = out_last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;

    rd_eol   = (rep_x_q == scale_m1_q) && (col_q == width_m1_q);
    rd_last  = rd_eol && (rep_y_q == scale_m1_q);
    out_load = !out_valid_q || out_ready;
    s1_adv   = s1_vld_q && out_load;
    out_xfer = out_valid_q && out_ready;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (start_legal) begin
            scale_m1_d  = scale - SCALE_W'(1);
            width_m1_d  = src_width - COL_W'(1);
            height_m1_d = src_height - ROW_W'(1);
`ifdef NNZ_HMIRROR_EN
            mirror_d    = mirror;
`endif
            row_d       = '0;
            col_d       = '0;
            busy_d      = 1'b1;
            state_d     = LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (in_valid && in_ready_q) begin
          wr_en = 1'b1;
          col_d = col_q + COL_W'(1);
          if (col_q == width_m1_q) begin
            col_d        = '0;
            rep_x_d      = '0;
            rep_y_d      = '0;
            issue_done_d = 1'b0;
            state_d      = EMIT;
          end
        end
      end

      EMIT: begin
        // Reads are issued ahead of the output register so that a
        // continuously ready sink sees one pixel per cycle, rep_y wraps included.
        rd_en = !issue_done_q && (!s1_vld_q || s1_adv);
        if (rd_en) begin
          rep_x_d = rep_x_q + SCALE_W'(1);
          if (rep_x_q == scale_m1_q) begin
            rep_x_d = '0;
            col_d   = col_q + COL_W'(1);
            if (col_q == width_m1_q) begin
              col_d = '0;
              if (rep_y_q == scale_m1_q) begin
                issue_done_d = 1'b1;
              end else begin
                rep_y_d = rep_y_q + SCALE_W'(1);
              end
            end
          end
        end
        if (out_xfer && out_last_q) begin
          col_d = '0;
          if (row_q == height_m1_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = LOAD;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Read-data stage: the buffer holds its output until the next read.
    if (rd_en) begin
      s1_vld_d  = 1'b1;
      s1_eol_d  = rd_eol;
      s1_last_d = rd_last;
    end else if (s1_adv) begin
      s1_vld_d = 1'b0;
    end

    if (out_load) begin
      out_valid_d = s1_vld_q;
      out_eol_d   = s1_vld_q && s1_eol_q;
      out_last_d  = s1_vld_q && s1_last_q;
      if (s1_vld_q) begin
        out_pixel_d = rd_data;
      end
    end

    in_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      scale_m1_q   <= '0;
      width_m1_q   <= '0;
      height_m1_q  <= '0;
`ifdef NNZ_HMIRROR_EN
      mirror_q     <= 1'b0;
`endif
      row_q        <= '0;
      col_q        <= '0;
      rep_x_q      <= '0;
      rep_y_q      <= '0;
      issue_done_q <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_eol_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      out_eol_q    <= 1'b0;
      out_last_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      scale_m1_q   <= scale_m1_d;
      width_m1_q   <= width_m1_d;
      height_m1_q  <= height_m1_d;
`ifdef NNZ_HMIRROR_EN
      mirror_q     <= mirror_d;
`endif
      row_q        <= row_d;
      col_q        <= col_d;
      rep_x_q      <= rep_x_d;
      rep_y_q      <= rep_y_d;
      issue_done_q <= issue_done_d;
      s1_vld_q     <= s1_vld_d;
      s1_eol_q     <= s1_eol_d;
      s1_last_q    <= s1_last_d;
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      out_eol_q    <= out_eol_d;
      out_last_q   <= out_last_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_eol   = out_eol_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_nearest_neighbor_zoom_nx.sv
// Scoreboard bench for nearest_neighbor_zoom_nx: golden replay sequence is
// queued per frame and popped on every output transfer.
module tb_nearest_neighbor_zoom_nx;

  localparam int PIXEL_W   = 8;
  localparam int MAX_SCALE = 4;
  localparam int SCALE_W   = 3;
  localparam int COL_W     = 9;
  localparam int ROW_W     = 8;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [SCALE_W-1:0] scale;
  logic [COL_W-1:0]   src_width;
  logic [ROW_W-1:0]   src_height;
  logic               mirror;
  logic               in_valid;
  logic [PIXEL_W-1:0] in_pixel;
  logic               in_ready;
  logic               out_valid;
  logic [PIXEL_W-1:0] out_pixel;
  logic               out_ready;
  logic               out_eol;
  logic               busy;
  logic               done;
  logic               cfg_err;

  typedef struct packed {
    logic [PIXEL_W-1:0] pix;
    logic               eol;
  } exp_t;

  exp_t               sb[$];
  logic [PIXEL_W-1:0] img[$];
  int                 n_pass  = 0;
  int                 n_total = 0;

  always #5 clk = ~clk;

  nearest_neighbor_zoom_nx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .scale      (scale),
    .src_width  (src_width),
    .src_height (src_height),
`ifdef NNZ_HMIRROR_EN
    .mirror     (mirror),
`endif
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .out_ready  (out_ready),
    .out_eol    (out_eol),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  // Runs one frame from img[]; compares every output against the scoreboard.
  task automatic run_frame(input int s, input int w, input int h, input int pct,
                           input int inj_cyc, input int abort_at, input logic mir,
                           input bit chk_bubbles, input string tag);
    int idx = 0, nout = 0, neol = 0, ndone = 0, ncfg = 0, bubbles = 0;
    int done_cyc = -1, last_x_cyc = -1, budget;
    bit finished = 0, stalled = 0, seen_valid = 0, aborted = 0;
    logic [PIXEL_W-1:0] held_pix;
    logic held_eol, in_x, out_x;
    exp_t e;
    int src_c;

    for (int r = 0; r < h; r++)
      for (int ry = 0; ry < s; ry++)
        for (int c = 0; c < w; c++)
          for (int rx = 0; rx < s; rx++) begin
            src_c = mir ? (w - 1 - c) : c;
            e.pix = img[r * w + src_c];
            e.eol = (c == w - 1) && (rx == s - 1);
            sb.push_back(e);
          end

    budget = h * (w + 4 * w * s * s + 20) + 100;
    @(posedge clk); #1;
    scale = SCALE_W'(s); src_width = COL_W'(w); src_height = ROW_W'(h);
    mirror = mir; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_pixel = img[0];
    out_ready = ($urandom_range(99) < pct);
    n_total++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
    else n_pass++;

    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        n_total++;
        if (out_valid !== 1'b1 || out_pixel !== held_pix || out_eol !== held_eol)
          $display("FAIL %s hold: got v=%b p=%h e=%b want v=1 p=%h e=%b",
                   tag, out_valid, out_pixel, out_eol, held_pix, held_eol);
        else n_pass++;
      end
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      stalled = out_valid && !out_ready;
      held_pix = out_pixel; held_eol = out_eol;
      if (out_valid) seen_valid = 1;
      else if (seen_valid && sb.size() > 0) bubbles++;
      if (out_x) begin
        nout++;
        if (out_eol) neol++;
        last_x_cyc = cyc;
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL %s extra_output: got p=%h want none", tag, out_pixel);
        end else begin
          e = sb.pop_front();
          if (out_pixel !== e.pix || out_eol !== e.eol)
            $display("FAIL %s pixel#%0d: got p=%h e=%b want p=%h e=%b",
                     tag, nout, out_pixel, out_eol, e.pix, e.eol);
          else n_pass++;
        end
      end
      if (done) begin ndone++; done_cyc = cyc; end
      if (cfg_err) ncfg++;
      @(posedge clk); #1;
      if (in_x) idx++;
      in_valid = (idx < w * h);
      if (idx < w * h) in_pixel = img[idx];
      out_ready = ($urandom_range(99) < pct);
      start = (cyc == inj_cyc);
      if (cyc == inj_cyc) begin
        scale = 2; src_width = 3; src_height = 1;
      end else begin
        scale = SCALE_W'(s); src_width = COL_W'(w); src_height = ROW_W'(h);
      end
      if (abort_at > 0 && nout >= abort_at) begin finished = 1; aborted = 1; end
      if (ndone > 0 && cyc >= done_cyc + 3) finished = 1;
    end
    start = 1'b0; in_valid = 1'b0;

    if (!finished) begin
      n_total++;
      $display("FAIL %s timeout: got %0d outputs, want %0d within budget",
               tag, nout, w * s * h * s);
    end else if (!aborted) begin
      n_total++;
      if (nout !== w * s * h * s) $display("FAIL %s out_count: got %0d want %0d", tag, nout, w * s * h * s);
      else n_pass++;
      n_total++;
      if (neol !== h * s) $display("FAIL %s eol_count: got %0d want %0d", tag, neol, h * s);
      else n_pass++;
      n_total++;
      if (ndone !== 1) $display("FAIL %s done_count: got %0d want 1", tag, ndone);
      else n_pass++;
      n_total++;
      if (done_cyc !== last_x_cyc + 1) $display("FAIL %s done_timing: got cyc %0d want %0d", tag, done_cyc, last_x_cyc + 1);
      else n_pass++;
      n_total++;
      if (ncfg !== 0) $display("FAIL %s cfg_err_during_frame: got %0d want 0", tag, ncfg);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL %s busy_after_done: got %b want 0", tag, busy);
      else n_pass++;
      if (chk_bubbles) begin
        n_total++;
        if (bubbles !== 0) $display("FAIL %s bubbles: got %0d want 0", tag, bubbles);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 0; scale = 0; src_width = 0; src_height = 0;
    mirror = 0; in_valid = 0; in_pixel = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({in_ready, out_valid, out_pixel, out_eol, busy, done, cfg_err} !== '0)
      $display("FAIL reset_outputs: got %b want 0",
               {in_ready, out_valid, out_pixel, out_eol, busy, done, cfg_err});
    else n_pass++;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({in_ready, out_valid, busy, done, cfg_err} !== '0)
      $display("FAIL idle_after_reset: got %b want 0", {in_ready, out_valid, busy, done, cfg_err});
    else n_pass++;
  endtask

  task automatic test_scale2_2x2();
    img = '{8'hA0, 8'hB0, 8'hC0, 8'hD0};
    run_frame(2, 2, 2, 100, -1, 0, 1'b0, 1'b0, "s2_2x2");
  endtask

  task automatic test_scale3_no_bubbles();
    img = '{8'h01, 8'h02, 8'h03};
    run_frame(3, 3, 1, 100, -1, 0, 1'b0, 1'b1, "s3_3x1");
  endtask

  task automatic test_random_stall();
    img.delete();
    for (int i = 0; i < 10; i++) img.push_back(PIXEL_W'($urandom));
    run_frame(4, 5, 2, 50, -1, 0, 1'b0, 1'b0, "s4_stall");
  endtask

  task automatic test_cfg_err();
    int cfg[3][3] = '{'{0, 4, 2}, '{MAX_SCALE + 1, 4, 2}, '{2, 0, 2}};
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      scale = SCALE_W'(cfg[k][0]); src_width = COL_W'(cfg[k][1]);
      src_height = ROW_W'(cfg[k][2]); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_total++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL cfg_err_case%0d: got err=%b busy=%b rdy=%b want err=1 busy=0 rdy=0",
                 k, cfg_err, busy, in_ready);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (cfg_err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL cfg_err_pulse%0d: got err=%b busy=%b rdy=%b want 0 0 0",
                 k, cfg_err, busy, in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_passthrough_busy_start();
    img.delete();
    for (int i = 0; i < 320 * 8; i++) img.push_back(PIXEL_W'($urandom));
    run_frame(1, 320, 8, 100, 500, 0, 1'b0, 1'b0, "s1_pass");
  endtask

  task automatic test_reset_mid_emit();
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(2, 2, 2, 100, -1, 10, 1'b0, 1'b0, "abort");
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if ({in_ready, out_valid, out_pixel, out_eol, busy, done, cfg_err} !== '0)
      $display("FAIL async_reset_outputs: got %b want 0",
               {in_ready, out_valid, out_pixel, out_eol, busy, done, cfg_err});
    else n_pass++;
    sb.delete();
    @(negedge clk); reset_n = 1'b1;
    img = '{8'hAA, 8'hBB};
`ifdef NNZ_HMIRROR_EN
    run_frame(2, 2, 1, 100, -1, 0, 1'b1, 1'b1, "after_reset_mirror");
`else
    run_frame(2, 2, 1, 100, -1, 0, 1'b0, 1'b1, "after_reset");
`endif
  endtask

  initial begin
    test_reset();
    test_scale2_2x2();
    test_scale3_no_bubbles();
    test_random_stall();
    test_cfg_err();
    test_passthrough_busy_start();
    test_reset_mid_emit();
    n_total++;
    if (sb.size() !== 0) $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
